// File: rtl/ps2_kbd_mmio_ctrl.sv
// ps2_kbd_mmio_ctrl
//   PS/2 keyboard receiver with an 8-bit scan-code FIFO and a polled MMIO read port.
//   Each PS/2 frame is deserialised into a scan code and pushed into the FIFO.
//   The CPU reads a status/data word. A selected read that sees ready=1 pops the head,
//   so make/break sequences are delivered in order.
//
// Ports
//   clk_i       system clock
//   reset_i     asynchronous, active-high reset
//   ps2_clk_i   PS/2 clock from the keyboard (asynchronous)
//   ps2_data_i  PS/2 data from the keyboard (asynchronous)
//   addr_i      CPU data address; addr_i[31:28]==BASE_HI selects this block
//   rd_en_i     CPU load strobe for the current cycle
//   rdata_o     {22'b0, ovf, ready, code[7:0]} when selected, otherwise 0
//   irq_o       registered FIFO-non-empty flag
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, a frame is accepted only if data+parity has odd parity.
//                        When undefined, only the start and stop bits qualify a frame.
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 on a PS/2 falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit; a good frame is pushed here

module ps2_kbd_mmio_ctrl #(
   parameter int         FIFO_AW     = 3,
   parameter int         TIMEOUT_CYC = 50000,
   parameter logic [3:0] BASE_HI     = 4'hA
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        ps2_clk_i,
   input  logic        ps2_data_i,
   input  logic [31:0] addr_i,
   input  logic        rd_en_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   // Synchronisers; the clock gets a third flop so the edge detect works on settled values.
   logic clk_s1_q, clk_s2_q, clk_s3_q;
   logic dat_s1_q, dat_s2_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk_i;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_data_i;
         dat_s2_q <= dat_s1_q;
      end
   end

   logic ps2_fall;
   logic bit_in;
   assign ps2_fall = clk_s3_q & ~clk_s2_q;
   assign bit_in   = dat_s2_q;

   // Receive FSM
   state_e          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            parity_ok;
   logic            push_req;

`ifdef PS2_PARITY_CHECK_EN
   logic par_q, par_d;
   assign parity_ok = ^{shift_q, par_q};
`else
   assign parity_ok = 1'b1;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         timer_q   <= '0;
`ifdef PS2_PARITY_CHECK_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         timer_q   <= timer_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q     <= par_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      timer_d   = timer_q;
      push_req  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_d     = par_q;
`endif
      if (ps2_fall) begin
         // Every edge restarts the inactivity window.
         timer_d = TW'(TIMEOUT_CYC - 1);
         case (state_q)
            S_IDLE: begin
               if (!bit_in) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {bit_in, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_d   = bit_in;
`endif
               state_d = S_STOP;
            end
            S_STOP: begin
               push_req = bit_in & parity_ok;
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         // Terminal count abandons a stalled partial frame.
         if (timer_q == '0) state_d = S_IDLE;
         else               timer_d = timer_q - 1'b1;
      end
   end

   // FIFO and CPU port
   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               irq_q;

   logic       sel, empty, full, pop, push, drop;
   logic [7:0] head;
   logic       unused_addr;

   assign unused_addr = ^addr_i[27:0];

   assign sel   = (addr_i[31:28] == BASE_HI);
   assign empty = (count_q == '0);
   // count never exceeds DEPTH, so its MSB alone marks full.
   assign full  = count_q[FIFO_AW];
   assign pop   = sel & rd_en_i & ~empty;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign push  = push_req & (~full | pop);
   assign drop  = push_req & full & ~pop;
   assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

   assign rdata_o = sel ? {22'b0, ovf_q, ~empty, head} : 32'b0;
   assign irq_o   = irq_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (drop)                ovf_d = 1'b1;
      else if (sel & rd_en_i)  ovf_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         irq_q    <= ~empty;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else if (push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_mmio_ctrl.sv
module tb_ps2_kbd_mmio_ctrl;

   localparam int TO    = 200;
   localparam int HALF  = 10;
   localparam int DEPTH = 8;
   localparam logic [31:0] KBD = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [31:0] addr;
   logic        rd_en;
   logic [31:0] rdata;
   logic        irq;

   always #5 clk = ~clk;

   ps2_kbd_mmio_ctrl #(
      .FIFO_AW    (3),
      .TIMEOUT_CYC(TO),
      .BASE_HI    (4'hA)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .ps2_clk_i (ps2_clk),
      .ps2_data_i(ps2_data),
      .addr_i    (addr),
      .rd_en_i   (rd_en),
      .rdata_o   (rdata),
      .irq_o     (irq)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model: an in-order byte queue, capacity DEPTH, plus a sticky overflow flag.
   byte unsigned mq[$];
   bit           m_ovf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit frame_good(input bit par_flip, input bit stop_bit);
`ifdef PS2_PARITY_CHECK_EN
      return stop_bit && !par_flip;
`else
      return stop_bit;
`endif
   endfunction

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      repeat (HALF) tick();
      ps2_clk = 1'b1;
   endtask

   task automatic cpu_read(input logic [31:0] a, input string tag, output logic [31:0] got);
      logic [31:0] exp;
      if (a[31:28] == 4'hA) begin
         exp = {22'b0, m_ovf, (mq.size() != 0), (mq.size() != 0) ? mq[0] : 8'h00};
         m_ovf = 1'b0;
         if (mq.size() != 0) void'(mq.pop_front());
      end else begin
         exp = 32'h0;
      end
      addr  = a;
      rd_en = 1'b1;
      #1;
      got = rdata;
      check(tag, rdata, exp);
      tick();
      rd_en = 1'b0;
      addr  = 32'h0;
   endtask

   task automatic model_push(input byte unsigned b, input bit good);
      if (good) begin
         if (mq.size() < DEPTH) mq.push_back(b);
         else                   m_ovf = 1'b1;
      end
   endtask

   // pop_at_stop places a single selected read on the very cycle the frame is pushed.
   task automatic send_frame(input byte unsigned b, input bit par_flip, input bit stop_bit,
                             input bit pop_at_stop);
      logic [31:0] got;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ par_flip);
      ps2_data = stop_bit;
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      if (pop_at_stop) begin
         tick();
         tick();
         cpu_read(KBD, "pop_with_push", got);
         repeat (HALF - 3) tick();
      end else begin
         repeat (HALF) tick();
      end
      ps2_clk = 1'b1;
      repeat (2) tick();
      model_push(b, frame_good(par_flip, stop_bit));
   endtask

   task automatic send_partial(input int nbits);
      ps2_bit(1'b0);
      for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
      repeat (TO + 1) tick();
   endtask

   task automatic check_irq(input string tag);
      tick();
      tick();
      check(tag, {31'b0, irq}, {31'b0, (mq.size() != 0)});
   endtask

   task automatic drain(input string tag);
      logic [31:0] got;
      int n;
      n = mq.size();
      for (int i = 0; i <= n; i++) cpu_read(KBD, tag, got);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_chk, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int          op;
      logic [3:0]  nib;

      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd_en    = 1'b0;
      addr     = 32'h0;
      m_ovf    = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Reset state
      cpu_read(KBD, "reset_rdata", got);
      check("reset_rdata_lit", got, 32'h0);
      check_irq("reset_irq");

      // Single frame, then empty
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      check_irq("irq_one");
      cpu_read(KBD, "one_frame", got);
      check("one_frame_lit", got, 32'h0000_011C);
      cpu_read(KBD, "one_frame_empty", got);
      check_irq("irq_empty");

      // Break code order
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      cpu_read(KBD, "break_f0", got);
      check("break_f0_lit", got, 32'h0000_01F0);
      cpu_read(KBD, "break_1c", got);

      // Overflow: nine frames into eight slots
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      cpu_read(KBD, "ovf_first", got);
      check("ovf_first_lit", got, 32'h0000_0301);
      drain("ovf_drain");

      // Bad parity
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      drain("bad_parity");

      // Bad stop bit is always discarded
      send_frame(8'h77, 1'b0, 1'b0, 1'b0);
      cpu_read(KBD, "bad_stop", got);
      check("bad_stop_lit", got, 32'h0);

      // Timeout recovery
      send_partial(5);
      send_frame(8'h29, 1'b0, 1'b1, 1'b0);
      cpu_read(KBD, "timeout_29", got);
      check("timeout_29_lit", got, 32'h0000_0129);
      cpu_read(KBD, "timeout_empty", got);

      // Push coincides with pop of a one-entry FIFO
      send_frame(8'h55, 1'b0, 1'b1, 1'b0);
      send_frame(8'h66, 1'b0, 1'b1, 1'b1);
      check_irq("irq_after_swap");
      cpu_read(KBD, "swap_new", got);
      check("swap_new_lit", got, 32'h0000_0166);
      cpu_read(KBD, "swap_empty", got);

      // Push coincides with pop of a full FIFO: no drop
      for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
      send_frame(8'h18, 1'b0, 1'b1, 1'b1);
      drain("full_swap");

      // Unselected read has no side effect
      send_frame(8'h42, 1'b0, 1'b1, 1'b0);
      cpu_read(32'hC000_0000, "unsel", got);
      check("unsel_lit", got, 32'h0);
      cpu_read(KBD, "unsel_then_sel", got);
      check("unsel_then_sel_lit", got, 32'h0000_0142);

      // Reset mid-frame with data queued
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      addr  = KBD;
      reset = 1'b1;
      #1;
      check("async_reset_rdata", rdata, 32'h0);
      check("async_reset_irq", {31'b0, irq}, 32'h0);
      mq.delete();
      m_ovf = 1'b0;
      tick();
      addr  = 32'h0;
      reset = 1'b0;
      tick();
      send_frame(8'h4B, 1'b0, 1'b1, 1'b0);
      cpu_read(KBD, "after_reset", got);

      // Randomised traffic against the queue model
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 99);
         if (op < 50) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 7) != 0), 1'b0);
         end else if (op < 85) begin
            cpu_read(KBD | 32'($urandom_range(0, 32'h0FFF_FFFF)), "rand_read", got);
         end else if (op < 95) begin
            do nib = 4'($urandom_range(0, 15)); while (nib == 4'hA);
            cpu_read({nib, 28'($urandom_range(0, 32'h0FFF_FFFF))}, "rand_unsel", got);
         end else begin
            send_partial($urandom_range(1, 9));
         end
         if (it % 10 == 9) check_irq("rand_irq");
      end
      drain("rand_drain");
      check_irq("final_irq");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
